// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALUOp/ALUControl codes, opcodes.
// The ILLEGAL state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package multicycle_control_unit_pkg;

  localparam int STATE_ENC_W = 4;

  typedef enum logic [STATE_ENC_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_ILLEGAL = 4'd11
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate format select: I/load 00, S 01, B 10, J 11, anything else 00.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return 2'b01;
      OP_BRANCH: return 2'b10;
      OP_JAL:    return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation decoder: maps the FSM's ALUOp plus funct3/funct7b5/op[5] to an ALUControl code.
module alu_op_decoder
  import multicycle_control_unit_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output alu_ctrl_t   alu_ctrl
);

  always_comb begin
    // NOTE: the output gets a default before the case so every path assigns it and no latch is inferred.
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multicycle RISC-V datapath with memory handshake and enable gating.
// Optional macro CTRL_ILLEGAL_TRAP_EN adds a sticky ILLEGAL trap state for unknown opcodes.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal
);

  logic [STATE_W-1:0] state_q;
  logic               running_q;
  state_t             state;
  state_t             state_d;

  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_update;
  logic       branch;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  alu_op_t    alu_op;
  alu_ctrl_t  alu_ctrl;

  assign state = state_t'(state_q[STATE_ENC_W-1:0]);

  // The state only advances once running is set, so the idle cycle after reset never skips a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only control registers are reset here; sequential state is updated with non-blocking assignments.
    if (!rst_n) begin
      state_q   <= STATE_W'(S_FETCH);
      running_q <= 1'b0;
    end else begin
      running_q <= 1'b1;
      if (running_q) state_q <= STATE_W'(state_d);
    end
  end

  always_comb begin
    state_d    = state;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (MemReady) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_d = S_ILLEGAL;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (op[5]),
    .alu_ctrl (alu_ctrl)
  );

  // funct3[0] distinguishes bne from beq, so one compare serves both branches.
  assign PCWrite    = running_q & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite    = running_q & ir_write;
  assign MemWrite   = running_q & mem_write;
  assign RegWrite   = running_q & reg_write;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ImmSrc     = imm_src_of(op);
  assign ALUControl = ALUCTRL_W'(alu_ctrl);

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal = (state == S_ILLEGAL);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected control sequences
// are generated from the instruction class and compared cycle by cycle against the outputs.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       mw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  int vectors = 0;
  int miscompares = 0;

  ctl_t  exp_q[$];
  logic  mr_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(3), .STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  function automatic ctl_t observed();
    ctl_t c;
    c = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
         ImmSrc, ALUControl, Illegal};
    return c;
  endfunction

  // Reference rules written straight from the instruction-set view.
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_LW || o == OP_I) return 2'b00;
    if (o == OP_SW)              return 2'b01;
    if (o == OP_BR)              return 2'b10;
    if (o == OP_JAL)             return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic sub);
    logic [2:0] table_v [8];
    table_v = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b100, 3'b000, 3'b011, 3'b010};
    if (f3 == 3'b000 && sub) return 3'b001;
    return table_v[f3];
  endfunction

  function automatic ctl_t blank();
    ctl_t c;
    c     = '0;
    c.imm = imm_of(op);
    return c;
  endfunction

  function automatic ctl_t idle_fetch();
    ctl_t c;
    c     = blank();
    c.b   = 2'b10;
    c.res = 2'b10;
    return c;
  endfunction

  task automatic push(input string nm, input ctl_t c, input logic mr);
    name_q.push_back(nm);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endtask

  function automatic logic rand_mr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    @(posedge clk);
    #1;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  // Expected cycle-by-cycle controls for the instruction currently on op/funct3/funct7b5/Zero.
  task automatic build_instr(input int fetch_wait, input int mem_wait);
    ctl_t c;
    for (int i = 0; i <= fetch_wait; i++) begin
      c     = idle_fetch();
      c.irw = (i == fetch_wait);
      c.pcw = (i == fetch_wait);
      push("fetch", c, i == fetch_wait);
    end
    c = blank(); c.a = 2'b01; c.b = 2'b01;
    push("decode", c, rand_mr());
    if (op == OP_LW || op == OP_SW) begin
      c = blank(); c.a = 2'b10; c.b = 2'b01;
      push("memadr", c, rand_mr());
      for (int i = 0; i <= mem_wait; i++) begin
        c = blank(); c.adr = 1'b1; c.mw = (op == OP_SW);
        push((op == OP_SW) ? "memwrite" : "memread", c, i == mem_wait);
      end
      if (op == OP_LW) begin
        c = blank(); c.res = 2'b01; c.rw = 1'b1;
        push("memwb", c, rand_mr());
      end
    end else if (op == OP_R || op == OP_I) begin
      c = blank(); c.a = 2'b10; c.b = (op == OP_I) ? 2'b01 : 2'b00;
      c.alu = funct_alu(funct3, funct7b5 & op[5]);
      push("exec", c, rand_mr());
      c = blank(); c.rw = 1'b1;
      push("aluwb", c, rand_mr());
    end else if (op == OP_BR) begin
      c = blank(); c.a = 2'b10; c.alu = 3'b001; c.pcw = Zero ^ funct3[0];
      push("branch", c, rand_mr());
    end else if (op == OP_JAL) begin
      c = blank(); c.a = 2'b01; c.b = 2'b10; c.pcw = 1'b1;
      push("jal", c, rand_mr());
      c = blank(); c.rw = 1'b1;
      push("aluwb", c, rand_mr());
    end
  endtask

  task automatic run_queue(input int max_cycles);
    ctl_t  e, o;
    string nm;
    int    k = 0;
    while (exp_q.size() > 0 && k < max_cycles) begin
      @(negedge clk);
      MemReady = mr_q.pop_front();
      #1;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      o  = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s op=%b f3=%b: observed %b required %b [pcw adr irw mw rw res a b imm alu ill]",
                 nm, op, funct3, o, e);
      end
      k++;
    end
    exp_q.delete();
    mr_q.delete();
    name_q.delete();
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; MemReady = 1'b1;
    #1;
    vectors++;
    if (observed() !== idle_fetch()) begin
      miscompares++;
      $display("FAIL %s_held: observed %b required %b", tag, observed(), idle_fetch());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (observed() !== idle_fetch()) begin
      miscompares++;
      $display("FAIL %s_release: observed %b required %b", tag, observed(), idle_fetch());
    end
  endtask

  task automatic test_reset();
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    apply_reset("reset");
  endtask

  task automatic test_rtype();
    set_instr(OP_R, 3'b000, 1'b1, 1'b0);
    build_instr(0, 0);
    run_queue(100);
    set_instr(OP_I, 3'b111, 1'b1, 1'b0);
    build_instr(1, 0);
    run_queue(100);
  endtask

  task automatic test_load_wait();
    set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
    build_instr(0, 3);
    run_queue(100);
  endtask

  task automatic test_store_wait();
    set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
    build_instr(0, 2);
    run_queue(100);
  endtask

  task automatic test_branch();
    logic [3:0] cases [4];
    cases = '{4'b0010, 4'b0011, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      set_instr(OP_BR, cases[i][3:1], 1'b0, cases[i][0]);
      build_instr(0, 0);
      run_queue(100);
    end
  endtask

  task automatic test_reset_mid_store();
    ctl_t exp_c;
    set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
    build_instr(0, 5);
    run_queue(4);
    #1;
    rst_n = 1'b0;
    #1;
    exp_c = idle_fetch();
    vectors++;
    if (observed() !== exp_c) begin
      miscompares++;
      $display("FAIL abort_store: observed %b required %b", observed(), exp_c);
    end
    apply_reset("abort_store");
    set_instr(OP_R, 3'b110, 1'b0, 1'b0);
    build_instr(0, 0);
    run_queue(100);
  endtask

  task automatic test_illegal();
    set_instr(OP_BAD, 3'b000, 1'b0, 1'b0);
    build_instr(0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      ctl_t c;
      for (int i = 0; i < 4; i++) begin
        c = blank(); c.ill = 1'b1;
        push("illegal", c, 1'b1);
      end
    end
    run_queue(100);
    apply_reset("after_illegal");
`else
    run_queue(100);
`endif
    set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
    build_instr(0, 0);
    run_queue(100);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    logic [6:0] bad [3];
    logic [6:0] o;
    int         n_ops;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_BAD};
    bad = '{7'b1111111, 7'b0110111, 7'b0000000};
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_ops = 6;
`else
    n_ops = 7;
`endif
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, n_ops - 1)];
      if (o == OP_BAD) o = bad[$urandom_range(0, 2)];
      set_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      build_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run_queue(100);
    end
  endtask

  initial begin
    rst_n = 1'b0; MemReady = 1'b0;
    op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_reset_mid_store();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: ALUCTRL_W, 3, ALUControl width (>=3); upper bits beyond bit 2 SHALL be zero.
REQ-002 Parameter: STATE_W, 4, state register width (>=4).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 op  in  7  instruction opcode, valid while IR holds the instruction.
REQ-007 funct3  in  3  instruction funct3.
REQ-008 funct7b5  in  1  instruction bit 30.
REQ-009 Zero  in  1  ALU zero flag.
REQ-010 MemReady  in  1  memory handshake; access completes in a cycle with MemReady=1.
REQ-011 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-012 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-013 ALUControl  out  ALUCTRL_W  ALU operation.
REQ-014 Illegal  out  1  illegal-opcode trap flag.

Function
REQ-015 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL (only with macro).
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite and PCUpdate only when MemReady=1; stay in FETCH while MemReady=0, else go to DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->see REQ-030.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; load->MEMREAD, store->MEMWRITE.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then MEMWB.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1, then FETCH.
REQ-021 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH; ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-023 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
REQ-024 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
REQ-025 PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])); beq and bne both supported.
REQ-026 ImmSrc from op, combinational: I/load 00, S 01, B 10, J 11, others 00.
REQ-027 ALU decode: ALUOp 00->add 000, 01->sub 001; 10 by funct3: 000 add, or sub when funct7b5&op[5]; 010 slt 101; 100 xor 100; 110 or 011; 111 and 010; other funct3->add. Never X.
REQ-028 Unused mux selects in any state SHALL drive 0, never X.

Reset
REQ-029 rst_n low: state=FETCH, Illegal=0, running flag=0; PCWrite, IRWrite, MemWrite, RegWrite forced 0 whenever running=0; running sets on first rising edge with rst_n high; reset mid-instruction abandons it without any write.

Configuration
REQ-030 Macro CTRL_ILLEGAL_TRAP_EN defined: unknown op in DECODE -> ILLEGAL, Illegal=1, all enables 0, held until reset. Undefined: unknown op -> FETCH (NOP), Illegal tied 0, no ILLEGAL state.

Structure
REQ-031 Shared package: state encoding enum, ALUOp codes, ALUControl codes, opcode constants.
REQ-032 Sub-module alu_op_decoder holds REQ-027; FSM, enable gating and ImmSrc stay in top.

Verification
REQ-033 Reset release, MemReady=1, op=0110011 funct3=000 funct7b5=1 -> FETCH,DECODE,EXECR(ALUControl=001),ALUWB(RegWrite=1), back to FETCH in 4 cycles.
REQ-034 lw with MemReady low 3 cycles in MEMREAD -> state held 3 cycles, RegWrite only in the single MEMWB cycle.
REQ-035 sw with MemReady=0 for 2 cycles -> MemWrite=1 for 3 cycles, then FETCH.
REQ-036 op=1100011 funct3=001 Zero=0 -> PCWrite=1 in BRANCH; same with Zero=1 -> PCWrite=0.
REQ-037 rst_n pulsed low in MEMWRITE -> immediate FETCH, MemWrite=0, no enables during the first cycle after release.
REQ-038 op=1111111 -> with macro Illegal=1 and no enables until reset; without macro, FETCH next cycle, Illegal=0.
